// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the operand-sequencer FSM encoding.
package alu_pkg;

  localparam int NB_OPCODE = 6;

  localparam logic [NB_OPCODE-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OPCODE-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OPCODE-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OPCODE-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OPCODE-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OPCODE-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OPCODE-1:0] OP_SRL = 6'b000010;
  localparam logic [NB_OPCODE-1:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_RESULT  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_op_check.sv
// Combinational opcode legality check against the eight supported ALU codes.
import alu_pkg::*;

module alu_op_check #(
  parameter int NB_OP = 6
) (
  input  logic [NB_OP-1:0] op,
  output logic             legal
);

  always_comb begin
    legal = 1'b0;
    case (op)
      NB_OP'(OP_ADD), NB_OP'(OP_SUB), NB_OP'(OP_AND), NB_OP'(OP_OR),
      NB_OP'(OP_XOR), NB_OP'(OP_SRA), NB_OP'(OP_SRL), NB_OP'(OP_NOR): legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects operand A, operand B and opcode from one inbound stream, fires the
// external ALU for one cycle, and holds the captured result until consumed.
import alu_pkg::*;

module alu_operand_sequencer #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_data_valid,
  output logic               o_data_ready,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_alu_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_result_valid,
  input  logic               i_result_ready,
  output logic               o_op_err
);

  seq_state_t state, state_nxt;
  logic       accept;
  logic       op_legal;
  logic       upper_nz;

  alu_op_check #(.NB_OP(NB_OP)) u_op_check (
    .op    (i_data[NB_OP-1:0]),
    .legal (op_legal)
  );

  // Bits above the opcode field must be zero for the word to be a clean opcode.
  generate
    if (NB_DATA > NB_OP) begin : g_upper
      assign upper_nz = |i_data[NB_DATA-1:NB_OP];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

  assign o_data_ready   = (state == ST_LOAD_A) || (state == ST_LOAD_B) || (state == ST_LOAD_OP);
  assign o_alu_valid    = (state == ST_EXEC);
  assign o_result_valid = (state == ST_RESULT);
  assign accept         = i_data_valid & o_data_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD_A:  if (accept) state_nxt = ST_LOAD_B;
      ST_LOAD_B:  if (accept) state_nxt = ST_LOAD_OP;
      ST_LOAD_OP: if (accept) state_nxt = ST_EXEC;
      ST_EXEC:    state_nxt = ST_RESULT;
      ST_RESULT:  if (i_result_ready) state_nxt = ST_LOAD_A;
      default:    state_nxt = ST_LOAD_A;
    endcase
    if (i_clear) state_nxt = ST_LOAD_A;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_LOAD_A;
      o_data_a <= '0;
      o_data_b <= '0;
      o_op     <= '0;
      o_result <= '0;
      o_op_err <= 1'b0;
    end else begin
      state <= state_nxt;
      // Abort drops any word and result capture in flight; registers keep their values.
      if (!i_clear) begin
        if (accept) begin
          case (state)
            ST_LOAD_A: begin
              o_data_a <= i_data;
              o_op_err <= 1'b0;
            end
            ST_LOAD_B: o_data_b <= i_data;
            ST_LOAD_OP: begin
              o_op     <= i_data[NB_OP-1:0];
              o_op_err <= upper_nz | ~op_legal;
            end
            default: ;
          endcase
        end
        if (state == ST_EXEC) o_result <= i_alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed and randomized checks of the operand sequencer against a transaction-level model.
module tb_alu_operand_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset, i_clear, i_data_valid, i_result_ready;
  logic [7:0] i_data, i_alu_result;
  logic       o_data_ready, o_alu_valid, o_result_valid, o_op_err;
  logic [7:0] o_data_a, o_data_b, o_result;
  logic [5:0] o_op;

  int ncmp  = 0;
  int nfail = 0;

  logic [5:0] legal_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

  alu_operand_sequencer #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_clear        (i_clear),
    .i_data         (i_data),
    .i_data_valid   (i_data_valid),
    .o_data_ready   (o_data_ready),
    .o_data_a       (o_data_a),
    .o_data_b       (o_data_b),
    .o_op           (o_op),
    .o_alu_valid    (o_alu_valid),
    .i_alu_result   (i_alu_result),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .i_result_ready (i_result_ready),
    .o_op_err       (o_op_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h03:   return 8'($signed(a) >>> b);
      6'h02:   return a >> b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic ref_err(input logic [7:0] word);
    logic hit = 1'b0;
    foreach (legal_ops[i]) if (word[5:0] == legal_ops[i]) hit = 1'b1;
    return (word[7:6] != 2'b00) || !hit;
  endfunction

  // Stand-in for the external ALU, fed from the sequencer's registered outputs.
  always_comb i_alu_result = ref_alu(o_data_a, o_data_b, o_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    i_data = w; i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] w);
    int gap = $urandom_range(0, 2);
    repeat (gap) begin
      i_data = 8'($urandom); i_data_valid = 1'b0; i_result_ready = 1'($urandom);
      tick();
    end
    send(w);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a, b, w, hold;
    i_reset = 1'b1; i_clear = 1'b0; i_data = 8'h00; i_data_valid = 1'b0; i_result_ready = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    chk("rst_a", o_data_a, 0);
    chk("rst_b", o_data_b, 0);
    chk("rst_op", o_op, 0);
    chk("rst_result", o_result, 0);
    chk("rst_err", o_op_err, 0);
    chk("rst_valids", {o_alu_valid, o_result_valid}, 0);
    chk("rst_ready", o_data_ready, 1);

    // ADD on consecutive valid cycles
    i_data_valid = 1'b1;
    i_data = 8'h05; tick();
    i_data = 8'h03; tick();
    i_data = 8'h20; tick();
    i_data_valid = 1'b0;
    chk("add_exec_alu_valid", o_alu_valid, 1);
    chk("add_exec_result_valid", o_result_valid, 0);
    chk("add_exec_ready", o_data_ready, 0);
    tick();
    chk("add_alu_pulse_end", o_alu_valid, 0);
    chk("add_result_valid", o_result_valid, 1);
    chk("add_result", o_result, 8'h08);
    chk("add_err", o_op_err, 0);
    i_result_ready = 1'b1; tick(); i_result_ready = 1'b0;
    chk("add_handshake_rv", o_result_valid, 0);
    chk("add_handshake_ready", o_data_ready, 1);

    // Illegal opcode, then back-pressure in RESULT
    send(8'h0F); send(8'h01); send(8'h3F); tick();
    chk("ill_op", o_op, 6'h3F);
    chk("ill_err", o_op_err, 1);
    chk("ill_result", o_result, 8'h00);
    chk("ill_rv", o_result_valid, 1);
    for (int i = 0; i < 10; i++) begin
      i_data = 8'($urandom); i_data_valid = 1'b1;
      tick();
      chk("bp_result", o_result, 8'h00);
      chk("bp_ready", o_data_ready, 0);
      chk("bp_rv", o_result_valid, 1);
      chk("bp_a", o_data_a, 8'h0F);
      chk("bp_b", o_data_b, 8'h01);
      chk("bp_op", o_op, 6'h3F);
    end
    i_data_valid = 1'b0; i_result_ready = 1'b1; tick(); i_result_ready = 1'b0;
    chk("bp_release_ready", o_data_ready, 1);
    chk("bp_release_rv", o_result_valid, 0);

    // Nonzero bits above the opcode field
    send(8'h07);
    chk("err_clear_on_a", o_op_err, 0);
    send(8'h04); send(8'hE0); tick();
    chk("upper_op", o_op, 6'h20);
    chk("upper_err", o_op_err, 1);
    chk("upper_result", o_result, 8'h0B);
    i_result_ready = 1'b1; tick(); i_result_ready = 1'b0;

    // Abort together with the B word
    send(8'h11);
    i_data = 8'h22; i_data_valid = 1'b1; i_clear = 1'b1;
    tick();
    i_data_valid = 1'b0; i_clear = 1'b0;
    chk("abort_ready", o_data_ready, 1);
    chk("abort_a_kept", o_data_a, 8'h11);
    chk("abort_b_kept", o_data_b, 8'h04);
    chk("abort_result_kept", o_result, 8'h0B);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_alu", o_alu_valid, 0);
    end
    send(8'h33);
    chk("abort_new_a", o_data_a, 8'h33);
    chk("abort_b_still", o_data_b, 8'h04);
    send(8'h01); send(8'h20); tick();
    chk("abort_then_add", o_result, 8'h34);
    i_result_ready = 1'b1; tick(); i_result_ready = 1'b0;

    // Random traffic
    for (int t = 0; t < 1000; t++) begin
      a = 8'($urandom); b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) w = 8'($urandom);
      else w = {2'b00, legal_ops[$urandom_range(0, 7)]};
      send_gap(a); send_gap(b); send_gap(w);
      i_result_ready = 1'b0;
      chk("rnd_exec", o_alu_valid, 1);
      tick();
      chk("rnd_rv", o_result_valid, 1);
      chk("rnd_result", o_result, ref_alu(a, b, w[5:0]));
      chk("rnd_err", o_op_err, ref_err(w));
      chk("rnd_op", o_op, w[5:0]);
      hold = o_result;
      repeat ($urandom_range(0, 3)) begin
        i_data = 8'($urandom); i_data_valid = 1'($urandom);
        tick();
        chk("rnd_hold", o_result, ref_alu(a, b, w[5:0]));
      end
      i_data_valid = 1'b0; i_result_ready = 1'b1; tick(); i_result_ready = 1'b0;
      chk("rnd_done", o_result_valid, 0);
      chk("rnd_done_ready", o_data_ready, 1);
    end

    // Reset in the middle of EXEC beats clear and a pending word
    send(8'h5A); send(8'h3C); send(8'h20);
    chk("mid_exec", o_alu_valid, 1);
    i_reset = 1'b1; i_clear = 1'b1; i_data_valid = 1'b1; i_data = 8'hAA;
    tick();
    i_reset = 1'b0; i_clear = 1'b0; i_data_valid = 1'b0;
    chk("mrst_a", o_data_a, 0);
    chk("mrst_b", o_data_b, 0);
    chk("mrst_op", o_op, 0);
    chk("mrst_result", o_result, 0);
    chk("mrst_err", o_op_err, 0);
    chk("mrst_valids", {o_alu_valid, o_result_valid}, 0);
    chk("mrst_ready", o_data_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
